// File: rtl/osc_meas_ctrl.sv
// osc_meas_ctrl: arms the NAND ring oscillator, lets it settle, counts its
// rising edges over a fixed window of clk cycles and reports the count.
module osc_meas_ctrl #(
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             osc_en,
  input  logic             osc_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [SET_W-1:0]  SET_LOAD  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, FINISH} state_t;

  state_t              state, next_state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                hist_q;
  logic                edge_det;
  logic [SET_W-1:0]    settle_cnt;
  logic [GATE_W-1:0]   gate_cnt;
  logic [CNT_W-1:0]    edge_cnt, edge_cnt_nxt;
  logic                sat_q, sat_nxt;
  logic                edge_hit, at_max;

  assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Bring the asynchronous oscillator output into clk and keep one history bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic plus the saturating next value of the edge counter
  always_comb begin
    next_state   = state;
    edge_hit     = (state == GATE) && edge_det;
    at_max       = (edge_cnt == CNT_MAX);
    edge_cnt_nxt = edge_cnt;
    sat_nxt      = sat_q;
    if (edge_hit) begin
      if (at_max) sat_nxt      = 1'b1;
      else        edge_cnt_nxt = edge_cnt + 1'b1;
    end
    unique case (state)
      IDLE:    if (start_i && !abort_i) next_state = SETTLE;
      SETTLE: begin
        if (abort_i)                 next_state = IDLE;
        else if (settle_cnt == '0)   next_state = GATE;
      end
      GATE: begin
        if (abort_i)                 next_state = IDLE;
        else if (gate_cnt == '0)     next_state = FINISH;
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Settle/gate down-counters and the per-run edge counter with saturation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat_q      <= 1'b0;
    end else begin
      edge_cnt <= edge_cnt_nxt;
      sat_q    <= sat_nxt;
      case (state)
        IDLE: begin
          if (next_state == SETTLE) begin
            settle_cnt <= SET_LOAD;
            edge_cnt   <= '0;
            sat_q      <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) gate_cnt   <= GATE_LOAD;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        GATE: begin
          if (gate_cnt != '0) gate_cnt <= gate_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs so osc_en never glitches on multi-bit state changes;
  // the result is captured on entry to FINISH so it is valid alongside done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc_en <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      osc_en <= (next_state == SETTLE) || (next_state == GATE);
      busy   <= (next_state != IDLE);
      done   <= (next_state == FINISH);
      if ((state == GATE) && (next_state == FINISH)) begin
        count <= edge_cnt_nxt;
        ovf   <= sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_osc_meas_ctrl.sv
// tb_osc_meas_ctrl: directed bench for osc_meas_ctrl. Instance a uses a
// 16-bit counter, instance b a 4-bit counter; both share start/abort.
module tb_osc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        osc_a = 1'b0;
  logic        osc_b = 1'b0;
  logic        osc_en_a, busy_a, done_a, ovf_a;
  logic [15:0] count_a;
  logic        osc_en_b, busy_b, done_b, ovf_b;
  logic [3:0]  count_b;

  int half_a = 5;
  int half_b = 2;
  int phase_a = 0;
  int phase_b = 0;
  int check_count = 0;
  int pass_count = 0;

  osc_meas_ctrl #(.GATE_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .osc_en(osc_en_a), .osc_in(osc_a), .busy(busy_a), .done(done_a),
    .count(count_a), .ovf(ovf_a)
  );

  osc_meas_ctrl #(.GATE_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .osc_en(osc_en_b), .osc_in(osc_b), .busy(busy_b), .done(done_b),
    .count(count_b), .ovf(ovf_b)
  );

  // 100 MHz system clock
  initial forever #5 clk = ~clk;

  // Oscillator models, updated on negedge; half period in clk cycles, 0 = held low
  initial forever begin
    @(negedge clk);
    if (half_a == 0) begin
      phase_a = 0;
      osc_a = 1'b0;
    end else begin
      phase_a++;
      if (phase_a >= half_a) begin
        phase_a = 0;
        osc_a = ~osc_a;
      end
    end
    if (half_b == 0) begin
      phase_b = 0;
      osc_b = 1'b0;
    end else begin
      phase_b++;
      if (phase_b >= half_b) begin
        phase_b = 0;
        osc_b = ~osc_b;
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Drive inputs at the negedge; the following posedge samples them
  task automatic applyStimulus(input logic s, input logic a);
    @(negedge clk);
    start_i = s;
    abort_i = a;
  endtask

  // One start pulse, then cycle-by-cycle checks; k indexes the state after edge k
  task automatic runFull(input int exp_a, input int exp_b, input logic exp_ovf_b);
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k <= 105; k++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("osc_en", osc_en_a, k <= 103);
      checkOutput("busy", busy_a, k <= 104);
      checkOutput("done", done_a, k == 104);
      if (k == 104) begin
        checkOutput("count_a", count_a, exp_a);
        checkOutput("ovf_a", ovf_a, 0);
        checkOutput("done_b", done_b, 1);
        checkOutput("count_b", count_b, exp_b);
        checkOutput("ovf_b", ovf_b, exp_ovf_b);
      end
    end
  endtask

  initial begin
    int done_seen;
    int pos [3];
    int n;

    $display("[TB] start");
    // Reset, then idle with oscillators running
    repeat (3) applyStimulus(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("idle_osc_en", osc_en_a, 0);
      checkOutput("idle_busy", busy_a, 0);
      checkOutput("idle_done", done_a, 0);
      checkOutput("idle_count", count_a, 0);
      checkOutput("idle_ovf", ovf_a, 0);
      checkOutput("idle_ovf_b", ovf_b, 0);
    end

    // Period-10 oscillator on a, period-4 on b (saturates 4-bit counter)
    runFull(10, 15, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b0);
    checkOutput("hold_count", count_a, 10);
    checkOutput("hold_ovf_b", ovf_b, 1);

    // b held low: result and overflow cleared by the new run
    half_b = 0;
    repeat (4) applyStimulus(1'b0, 1'b0);
    runFull(10, 0, 1'b0);

    // Abort at GATE cycle 50 (state after edge 54)
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k <= 54; k++) begin
      applyStimulus(1'b0, k == 54);
      checkOutput("pre_abort_osc_en", osc_en_a, 1);
    end
    done_seen = 0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("abort_osc_en", osc_en_a, 0);
    checkOutput("abort_busy", busy_a, 0);
    for (int k = 0; k < 80; k++) begin
      applyStimulus(1'b0, 1'b0);
      if (done_a) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);
    checkOutput("abort_count", count_a, 10);
    runFull(10, 0, 1'b0);

    // Start re-pulsed in SETTLE and GATE is ignored
    applyStimulus(1'b1, 1'b0);
    done_seen = 0;
    for (int k = 0; k < 130; k++) begin
      applyStimulus((k == 2) || (k == 50), 1'b0);
      if (done_a) begin
        done_seen++;
        checkOutput("repulse_done_pos", k, 104);
      end
    end
    checkOutput("repulse_one_done", done_seen, 1);

    // Start held high: back-to-back runs
    pos[0] = -1000; pos[1] = -1000; pos[2] = -1000;
    n = 0;
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 400 && n < 3; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (done_a) begin
        pos[n] = k;
        n++;
      end
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("held_done_cnt", n, 3);
    checkOutput("held_first", pos[0], 104);
    checkOutput("held_gap1", pos[1] - pos[0], 106);
    checkOutput("held_gap2", pos[2] - pos[1], 106);
    repeat (5) applyStimulus(1'b0, 1'b0);
    checkOutput("held_idle_busy", busy_a, 0);

    // Asynchronous reset mid-GATE
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 60; k++) applyStimulus(1'b0, 1'b0);
    checkOutput("pre_rst_osc_en", osc_en_a, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_osc_en", osc_en_a, 0);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_count", count_a, 0);
    checkOutput("rst_done", done_a, 0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 120; k++) begin
      applyStimulus(1'b0, 1'b0);
      if (done_a || busy_a || osc_en_a) done_seen++;
    end
    checkOutput("post_rst_quiet", done_seen, 0);
    checkOutput("post_rst_count", count_a, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
